// File: rtl/ats_gen.sv
// ats_gen: round-robin arbitrated shift-add multiplier with saturated result.
// Optional feature macro: ATS_ACCUM_EN (adds clr_acc and a running accumulator).
module ats_gen #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 24,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ATS_ACCUM_EN
    input  logic                  clr_acc,
`endif
    input  logic [NCH-1:0]        req,
    input  logic [NCH*CTRL_W-1:0] ctrlA,
    input  logic [NCH*CTRL_W-1:0] ctrlB,
    output logic [NCH-1:0]        gnt,
    output logic                  ready,
    output logic [1:0]            stat,
    output logic [DATA_W-1:0]     data
);

    localparam int PW   = 2 * CTRL_W;
    localparam int EW   = ((PW > DATA_W) ? PW : DATA_W) + 1;
    localparam int CW   = $clog2(CTRL_W + 1);
    localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [PTRW-1:0]     r_ptr, r_idx, w_sel;
    logic [NCH-1:0]      w_gnt_oh;
    logic                w_found;
    logic [CTRL_W-1:0]   w_a_sel, w_b_sel;
    logic [PW-1:0]       r_ap, r_prod;
    logic [CTRL_W-1:0]   r_bp;
    logic [CW-1:0]       r_cnt;
    logic [NCH-1:0]      r_gnt, w_gnt_nxt;
    logic                r_ready, w_ready_nxt;
    logic [1:0]          r_stat, w_stat_nxt, w_res_stat;
    logic [DATA_W-1:0]   r_data, w_data_nxt, w_res;
    logic [EW-1:0]       w_prod_ext;
    logic                w_prod_ovf;
    logic [DATA_W-1:0]   w_prod_sat;
`ifdef ATS_ACCUM_EN
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W:0]     w_acc_sum;
    logic                w_acc_ovf;
    logic [DATA_W-1:0]   w_acc_sat;
`endif

    assign gnt   = r_gnt;
    assign ready = r_ready;
    assign stat  = r_stat;
    assign data  = r_data;

    // Round-robin search: channels at/above the pointer first, then wrap below it.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_gnt_oh = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!w_found && req[c] && (c >= 32'(r_ptr))) begin
                w_found     = 1'b1;
                w_sel       = PTRW'(c);
                w_gnt_oh[c] = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!w_found && req[c] && (c < 32'(r_ptr))) begin
                w_found     = 1'b1;
                w_sel       = PTRW'(c);
                w_gnt_oh[c] = 1'b1;
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_gnt_oh[c]) begin
                w_a_sel = ctrlA[c*CTRL_W +: CTRL_W];
                w_b_sel = ctrlB[c*CTRL_W +: CTRL_W];
            end
        end
    end

    // Saturation of the finished product (and of the running sum when enabled).
    always_comb begin
        w_prod_ext = EW'(r_prod);
        w_prod_ovf = |(w_prod_ext >> DATA_W);
        w_prod_sat = w_prod_ovf ? '1 : w_prod_ext[DATA_W-1:0];
`ifdef ATS_ACCUM_EN
        w_acc_sum  = {1'b0, r_acc} + {1'b0, w_prod_sat};
        w_acc_ovf  = w_acc_sum[DATA_W];
        w_acc_sat  = w_acc_ovf ? '1 : w_acc_sum[DATA_W-1:0];
        if (clr_acc) begin
            w_res      = '0;
            w_res_stat = 2'b10;
        end else begin
            w_res      = w_acc_sat;
            w_res_stat = (w_prod_ovf || w_acc_ovf) ? 2'b11 : 2'b10;
        end
`else
        w_res      = w_prod_sat;
        w_res_stat = w_prod_ovf ? 2'b11 : 2'b10;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == CW'(CTRL_W - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output next values; ready is registered so it appears the cycle after DONE.
    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_stat_nxt  = r_stat;
        w_data_nxt  = r_data;
        w_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_gnt_nxt  = w_gnt_oh;
                    w_stat_nxt = 2'b01;
                end else begin
                    w_gnt_nxt  = '0;
                    w_stat_nxt = 2'b00;
                end
            end
            S_DONE: begin
                w_ready_nxt = 1'b1;
                w_data_nxt  = w_res;
                w_stat_nxt  = w_res_stat;
            end
            default: ;
        endcase
    end

    // Output registers and multiplier datapath (A shifts left, B shifts right).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt   <= '0;
            r_ready <= 1'b0;
            r_stat  <= 2'b00;
            r_data  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_ap    <= '0;
            r_bp    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_ready <= w_ready_nxt;
            r_stat  <= w_stat_nxt;
            r_data  <= w_data_nxt;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_idx  <= w_sel;
                        r_ap   <= PW'(w_a_sel);
                        r_bp   <= w_b_sel;
                        r_prod <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_MUL: begin
                    if (r_bp[0]) r_prod <= r_prod + r_ap;
                    r_ap  <= r_ap << 1;
                    r_bp  <= r_bp >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    r_ptr <= (r_idx == PTRW'(NCH - 1)) ? '0 : r_idx + PTRW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ATS_ACCUM_EN
    // Accumulator: clear has priority in every state, including DONE.
    always_ff @(posedge clk) begin
        if (!reset)                 r_acc <= '0;
        else if (clr_acc)           r_acc <= '0;
        else if (r_state == S_DONE) r_acc <= w_acc_sat;
    end
`endif

endmodule

// File: tb/tb_ats_gen.sv
// tb_ats_gen: directed self-checking bench for ats_gen (CTRL_W=16, DATA_W=24, NCH=2).
module tb_ats_gen;

    logic        clk;
    logic        reset;
`ifdef ATS_ACCUM_EN
    logic        clr_acc;
`endif
    logic [1:0]  req;
    logic [31:0] ctrlA;
    logic [31:0] ctrlB;
    logic [1:0]  gnt;
    logic        ready;
    logic [1:0]  stat;
    logic [23:0] data;

    int checks   = 0;
    int failures = 0;

    ats_gen #(.CTRL_W(16), .DATA_W(24), .NCH(2)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef ATS_ACCUM_EN
        .clr_acc(clr_acc),
`endif
        .req   (req),
        .ctrlA (ctrlA),
        .ctrlB (ctrlB),
        .gnt   (gnt),
        .ready (ready),
        .stat  (stat),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one single-channel op and returns what was observed; operands are
    // inverted right after the grant so late changes would corrupt the result.
    task automatic do_op(input int ch, input logic [15:0] a, input logic [15:0] b,
                         output logic [1:0] g0, output logic [1:0] s0, output int lat,
                         output logic [23:0] d, output logic [1:0] s, output logic [1:0] g,
                         output logic rdy_after, output logic [1:0] s_after);
        @(negedge clk);
        if (ch == 0) begin
            ctrlA = {16'h0, a}; ctrlB = {16'h0, b}; req = 2'b01;
        end else begin
            ctrlA = {a, 16'h0}; ctrlB = {b, 16'h0}; req = 2'b10;
        end
        @(negedge clk);
        g0 = gnt; s0 = stat;
        ctrlA = ~ctrlA; ctrlB = ~ctrlB;
        lat = -1; d = '0; s = '0; g = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = k; d = data; s = stat; g = gnt;
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
        rdy_after = ready; s_after = stat;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 2'b11; ctrlA = 32'h0003_0005; ctrlB = 32'h0007_0009;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ((ready !== 1'b0) || (stat !== 2'b00) || (data !== 24'h0) || (gnt !== 2'b00)) begin
                failures++;
                $display("FAIL reset_cycle%0d ready=%b stat=%b data=%h gnt=%b exp 0/00/000000/00",
                         k, ready, stat, data, gnt);
            end
        end
        req = 2'b00;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [1:0] g0, s0, s, g, s_after; int lat; logic [23:0] d; logic ra;
        do_op(0, 16'd3, 16'd5, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (g0 !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", g0); end
        checks++; if (s0 !== 2'b01) begin failures++; $display("FAIL single_busy got=%b exp=01", s0); end
        checks++; if (lat !== 17) begin failures++; $display("FAIL single_latency got=%0d exp=17", lat); end
        checks++; if (d !== 24'd15) begin failures++; $display("FAIL single_data got=%0d exp=15", d); end
        checks++; if (s !== 2'b10) begin failures++; $display("FAIL single_stat got=%b exp=10", s); end
        checks++; if (g !== 2'b01) begin failures++; $display("FAIL single_gnt_at_ready got=%b exp=01", g); end
        checks++; if (ra !== 1'b0) begin failures++; $display("FAIL single_ready_pulse got=%b exp=0", ra); end
        checks++; if (s_after !== 2'b00) begin failures++; $display("FAIL single_idle_stat got=%b exp=00", s_after); end
        checks++; if (data !== 24'd15) begin failures++; $display("FAIL single_data_hold got=%0d exp=15", data); end
        // Channel 1 alone: 1234*56 = 69104
        do_op(1, 16'd1234, 16'd56, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (g !== 2'b10) begin failures++; $display("FAIL ch1_gnt got=%b exp=10", g); end
        checks++; if (d !== 24'd69104) begin failures++; $display("FAIL ch1_data got=%0d exp=69104", d); end
    endtask

    task automatic test_saturate;
        logic [1:0] g0, s0, s, g, s_after; int lat; logic [23:0] d; logic ra;
        do_op(0, 16'hFFFF, 16'hFFFF, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'hFFFFFF) begin failures++; $display("FAIL sat_data got=%h exp=ffffff", d); end
        checks++; if (s !== 2'b11) begin failures++; $display("FAIL sat_stat got=%b exp=11", s); end
        // 0xFFF*0xFFF = 0xFFE001 fits in 24 bits
        do_op(0, 16'h0FFF, 16'h0FFF, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'hFFE001) begin failures++; $display("FAIL fit_data got=%h exp=ffe001", d); end
        checks++; if (s !== 2'b10) begin failures++; $display("FAIL fit_stat got=%b exp=10", s); end
        // 0x1000*0x1000 = 2^24, one past the limit
        do_op(0, 16'h1000, 16'h1000, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'hFFFFFF) begin failures++; $display("FAIL edge_data got=%h exp=ffffff", d); end
        checks++; if (s !== 2'b11) begin failures++; $display("FAIL edge_stat got=%b exp=11", s); end
    endtask

    task automatic test_back_to_back;
        int n;
        int cyc[4];
        logic [1:0]  gq[4];
        logic [23:0] dq[4];
        logic [1:0]  sq[4];
        logic [1:0]  gexp[4];
        logic [23:0] dexp[4];
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
        dexp = '{24'd6, 24'd35, 24'd6, 24'd35};
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        ctrlA = {16'd5, 16'd2}; ctrlB = {16'd7, 16'd3}; req = 2'b11;
        n = 0;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (n < 4) begin
                    cyc[n] = i; gq[n] = gnt; dq[n] = data; sq[n] = stat;
                end
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
        if (n >= 4) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ((gq[j] !== gexp[j]) || (dq[j] !== dexp[j]) || (sq[j] !== 2'b10) ||
                    (cyc[j] !== 18 + 18 * j)) begin
                    failures++;
                    $display("FAIL b2b_op%0d gnt=%b data=%0d stat=%b cycle=%0d exp %b/%0d/10/%0d",
                             j, gq[j], dq[j], sq[j], cyc[j], gexp[j], dexp[j], 18 + 18 * j);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        logic [23:0] d;
        logic [1:0] s;
        @(negedge clk);
        ctrlA = {16'h0, 16'd9}; ctrlB = {16'h0, 16'd9}; req = 2'b01;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_gnt got=%b exp=01", gnt); end
        for (int k = 0; k < 4; k++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ((ready !== 1'b0) || (stat !== 2'b00) || (gnt !== 2'b00) || (data !== 24'h0)) begin
            failures++;
            $display("FAIL abort_state ready=%b stat=%b gnt=%b data=%h exp 0/00/00/000000",
                     ready, stat, gnt, data);
        end
        reset = 1'b1;
        lat = -1; d = '0; s = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = k; d = data; s = stat;
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (lat !== 18) begin failures++; $display("FAIL restart_latency got=%0d exp=18", lat); end
        checks++;
        if ((d !== 24'd81) || (s !== 2'b10)) begin
            failures++; $display("FAIL restart_result data=%0d stat=%b exp 81/10", d, s);
        end
    endtask

`ifdef ATS_ACCUM_EN
    task automatic test_accum;
        logic [1:0] g0, s0, s, g, s_after; int lat; logic [23:0] d; logic ra;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        do_op(0, 16'd100, 16'd100, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'd10000) begin failures++; $display("FAIL acc_first got=%0d exp=10000", d); end
        do_op(0, 16'd100, 16'd100, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'd20000) begin failures++; $display("FAIL acc_second got=%0d exp=20000", d); end
        @(negedge clk); clr_acc = 1'b1;
        @(negedge clk); clr_acc = 1'b0;
        do_op(0, 16'd7, 16'd7, g0, s0, lat, d, s, g, ra, s_after);
        checks++; if (d !== 24'd49) begin failures++; $display("FAIL acc_after_clr got=%0d exp=49", d); end
        do_op(0, 16'hFFFF, 16'hFFFF, g0, s0, lat, d, s, g, ra, s_after);
        checks++;
        if ((d !== 24'hFFFFFF) || (s !== 2'b11)) begin
            failures++; $display("FAIL acc_sat1 data=%h stat=%b exp ffffff/11", d, s);
        end
        do_op(0, 16'hFFFF, 16'hFFFF, g0, s0, lat, d, s, g, ra, s_after);
        checks++;
        if ((d !== 24'hFFFFFF) || (s !== 2'b11)) begin
            failures++; $display("FAIL acc_sat2 data=%h stat=%b exp ffffff/11", d, s);
        end
        clr_acc = 1'b1;
        do_op(0, 16'd7, 16'd7, g0, s0, lat, d, s, g, ra, s_after);
        clr_acc = 1'b0;
        checks++;
        if ((d !== 24'd0) || (s !== 2'b10)) begin
            failures++; $display("FAIL acc_clr_in_done data=%0d stat=%b exp 0/10", d, s);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; req = 2'b00; ctrlA = '0; ctrlB = '0;
`ifdef ATS_ACCUM_EN
        clr_acc = 1'b0;
`endif
        test_reset();
        test_single();
        test_saturate();
        test_back_to_back();
        test_reset_mid_mul();
`ifdef ATS_ACCUM_EN
        test_accum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
